// File: rtl/tty_pkg.sv
// Shared types and constants for the teletype transmit scheduler.
package tty_pkg;

    localparam int CHAR_W       = 8;
    // 137.5 kHz system clock divides exactly to 110 baud
    localparam int SYS_CLK_HZ   = 137_500;
    localparam int BAUD_110_DIV = SYS_CLK_HZ / 110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        CLR  = 3'd3,
        GAP  = 3'd4
    } tty_state_e;

endpackage

// File: rtl/tty_rr_arb.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping at NREQ.
module tty_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             found_o
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_i[(int'(ptr_i) + off) % NREQ]) begin
                grant_o = IDX_W'((int'(ptr_i) + off) % NREQ);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tty_tx_sched.sv
// Shares one teletype transmitter between NREQ sources; generates the shift clock.
// Build option: TTY_TX_SCHED_PRIO_EN gives requester 0 fixed top priority.
module tty_tx_sched
    import tty_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int BAUD_DIV  = BAUD_110_DIV,
    parameter int GAP_TICKS = 2,
    parameter int TMO_TICKS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [CHAR_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_shift_clk,
    output logic                 tx_load,
    output logic [CHAR_W-1:0]    tx_data,
    input  logic                 tx_flag,
    output logic                 tx_flag_clr,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 tmo_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int BD_W  = $clog2(BAUD_DIV);
    localparam int TK_W  = $clog2(TMO_TICKS + 1);

    tty_state_e        state_q, state_d;
    logic [BD_W-1:0]   baud_q;
    logic [TK_W-1:0]   tick_q, tick_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CHAR_W-1:0] data_q, data_d;
    logic              tmo_q, tmo_d;

    logic [NREQ-1:0]   arb_req;
    logic [IDX_W-1:0]  arb_grant;
    logic              arb_found;
    logic [IDX_W-1:0]  pick;
    logic              pick_any;

`ifdef TTY_TX_SCHED_PRIO_EN
    assign arb_req  = req_valid & ~NREQ'(1);
    assign pick     = req_valid[0] ? '0 : arb_grant;
    assign pick_any = req_valid[0] | arb_found;
`else
    assign arb_req  = req_valid;
    assign pick     = arb_grant;
    assign pick_any = arb_found;
`endif

    tty_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .found_o (arb_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= '0;
        end else if (baud_q == BD_W'(BAUD_DIV - 1)) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + BD_W'(1);
        end
    end

    assign tx_shift_clk = (baud_q == BD_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    // Handshake: a requester holds req_valid/req_data until its one-clk req_ready;
    // requests are only sampled in IDLE, so dropping req_valid beforehand withdraws it.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    data_d  = req_data[int'(pick)*CHAR_W +: CHAR_W];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tick_d  = '0;
                state_d = WAIT;
`ifdef TTY_TX_SCHED_PRIO_EN
                if (grant_q != '0)
`endif
                rr_d = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
            WAIT: begin
                // Flag is checked first so a flag coinciding with timeout wins.
                if (tx_flag) begin
                    tmo_d   = 1'b0;
                    state_d = CLR;
                end else if (tx_shift_clk) begin
                    if (int'(tick_q) + 1 >= TMO_TICKS) begin
                        tmo_d   = 1'b1;
                        state_d = CLR;
                    end else begin
                        tick_d = tick_q + TK_W'(1);
                    end
                end
            end
            CLR: begin
                tick_d  = '0;
                state_d = (GAP_TICKS == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (tx_shift_clk) begin
                    if (int'(tick_q) + 1 >= GAP_TICKS) begin
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOAD) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign tx_load     = (state_q == LOAD);
    assign tx_flag_clr = (state_q == CLR);
    assign busy        = (state_q != IDLE);
    assign tx_data     = data_q;
    assign grant_id    = 3'(grant_q);
    assign tmo_err     = tmo_q;

endmodule
